uart_tx_fifo: RTL and testbench

Byte buffer and launch sequencer directly upstream of `uartTransmiter`. Accepts bytes from a host-side write port into a circular FIFO and hands them one at a time to the transmitter: it pulses `dataValid` with the byte on `P_BYTE`, then waits for `done` before launching the next byte. The host can burst up to DEPTH bytes without tracking UART bit timing.

---
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Desc     : Circular byte FIFO that launches one byte at a time into
//            uartTransmiter (dataValid pulse, then wait for done).
//            Optional watchdog: define UART_TX_FIFO_WDOG_EN.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int WDOG_CLKS = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic              wdog_err
);

  localparam logic [0:0]      c_IDLE      = 1'b0;
  localparam logic [0:0]      c_WAIT_DONE = 1'b1;
  localparam logic [ADDR_W:0] c_FULL_CNT  = (ADDR_W + 1)'(DEPTH);

  if (DEPTH < 2 || DEPTH != (1 << ADDR_W) || WDOG_CLKS < 1) begin : g_param_check
    $fatal(1, "uart_tx_fifo: illegal DEPTH/ADDR_W/WDOG_CLKS");
  end

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_ovf;
  logic              r_tx_dv;
  logic [7:0]        r_tx_byte;
  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              w_wr_acc;
  logic              w_can_launch;
  logic              w_pop;
  logic              w_wdog_to;
  logic [ADDR_W:0]   w_count_nxt;

  // Acceptance uses the registered full flag, so a same-cycle pop never frees room.
  assign w_wr_acc     = wr_en && !r_full;
  assign w_can_launch = (r_count != '0) && !tx_active && !tx_done;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:      if (w_can_launch)          w_state_nxt = c_WAIT_DONE;
      c_WAIT_DONE: if (tx_done || w_wdog_to)  w_state_nxt = c_IDLE;
      default:                                w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_pop = (r_state == c_IDLE) && w_can_launch;
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_pop})
      2'b10:   w_count_nxt = r_count + (ADDR_W + 1)'(1);
      2'b01:   w_count_nxt = r_count - (ADDR_W + 1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_ovf     <= 1'b0;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'h00;
    end else begin
      if (w_wr_acc)          r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (wr_en && r_full)   r_ovf    <= 1'b1;
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
        r_tx_byte <= r_mem[r_rd_ptr];
      end
      r_tx_dv <= w_pop;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
  end

`ifdef UART_TX_FIFO_WDOG_EN
  localparam int c_WDOG_W = $clog2(WDOG_CLKS + 1);

  logic [c_WDOG_W-1:0] r_wdog_cnt;
  logic                r_wdog_err;

  assign w_wdog_to = (r_state == c_WAIT_DONE) && !tx_done &&
                     (r_wdog_cnt == c_WDOG_W'(WDOG_CLKS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if (r_state == c_WAIT_DONE) r_wdog_cnt <= r_wdog_cnt + c_WDOG_W'(1);
      else                        r_wdog_cnt <= '0;
      if (w_wdog_to)              r_wdog_err <= 1'b1;
    end
  end

  assign wdog_err = r_wdog_err;
`else
  assign w_wdog_to = 1'b0;
  assign wdog_err  = 1'b0;
`endif

  assign full    = r_full;
  assign empty   = r_empty;
  assign count   = r_count;
  assign ovf     = r_ovf;
  assign tx_dv   = r_tx_dv;
  assign tx_byte = r_tx_byte;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// tb_uart_tx_fifo: cycle vector table plus directed sequences against a
// behavioural transmitter model (FRAME clocks active, then a one-clock done).
module tb_uart_tx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int FRAME  = 20;
  localparam int NVEC   = 19;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic              tx_active;
  logic              tx_done;
  logic              wdog_err;

  logic model_en, h_active, h_done;
  logic m_active, m_done;
  assign tx_active = model_en ? m_active : h_active;
  assign tx_done   = model_en ? m_done   : h_done;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WDOG_CLKS(100)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .ovf(ovf),
    .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_active(tx_active),
    .tx_done(tx_done), .wdog_err(wdog_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Transmitter model
  initial begin
    m_active = 1'b0;
    m_done   = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (model_en && tx_dv) begin
        m_active = 1'b1;
        repeat (FRAME) @(posedge clk);
        #1;
        m_active = 1'b0;
        m_done   = 1'b1;
        @(posedge clk); #1;
        m_done   = 1'b0;
      end
    end
  end

  // Launch monitor
  logic [7:0] lq [$];
  int         dbl;
  logic       prev_dv;
  initial begin
    dbl     = 0;
    prev_dv = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_dv === 1'b1) begin
        lq.push_back(tx_byte);
        if (prev_dv === 1'b1) dbl++;
      end
      prev_dv = tx_dv;
    end
  end

  typedef struct packed {
    logic            wr;
    logic [7:0]      d;
    logic            act;
    logic            done;
    logic [ADDR_W:0] cnt;
    logic            emp;
    logic            ful;
    logic            dv;
    logic [7:0]      byt;
    logic            ov;
  } vec_t;

  vec_t vt [NVEC];
  int   n_chk, n_err;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_launches(input int n, input int budget, input string nm);
    for (int c = 0; c < budget && lq.size() < n; c++) tick();
    chk(nm, lq.size(), n);
  endtask

  function automatic logic [31:0] lq_at(input int i);
    return (i < lq.size()) ? {24'h0, lq[i]} : 32'hFFFF;
  endfunction

  initial begin
    int              base;
    int              b2;
    logic [ADDR_W:0] peak;

    n_chk = 0;
    n_err = 0;
    // wr, data, act, done | count, empty, full, dv, byte, ovf
    vt[0]  = '{1'b1, 8'hAB, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 8'hAB, 1'b0};
    vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'hAB, 1'b0};
    vt[3]  = '{1'b1, 8'h11, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'hAB, 1'b0};
    vt[4]  = '{1'b1, 8'h22, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'hAB, 1'b0};
    vt[5]  = '{1'b1, 8'h33, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 8'hAB, 1'b0};
    vt[6]  = '{1'b1, 8'h44, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
    vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0};
    vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0};
    vt[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0};
    vt[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0};
    vt[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0};
    vt[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0};
    vt[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0};
    vt[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0};
    vt[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0};
    vt[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'h44, 1'b0};
    vt[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h44, 1'b0};

    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    model_en = 1'b0;
    h_active = 1'b0;
    h_done   = 1'b0;
    repeat (3) tick();
    chk("reset_state", {count, empty, full, ovf, tx_dv, tx_byte, wdog_err},
        {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
    rst_n = 1'b1;

    // Single byte, launch gating and simultaneous write/pop
    for (int i = 0; i < NVEC; i++) begin
      wr_en    = vt[i].wr;
      wr_data  = vt[i].d;
      h_active = vt[i].act;
      h_done   = vt[i].done;
      tick();
      chk($sformatf("vec%0d", i), {count, empty, full, tx_dv, tx_byte, ovf},
          {vt[i].cnt, vt[i].emp, vt[i].ful, vt[i].dv, vt[i].byt, vt[i].ov});
    end
    wr_en = 1'b0;

    // Burst 01..10 with pointers starting mid-array so they wrap
    model_en = 1'b1;
    base     = lq.size();
    peak     = '0;
    for (int i = 1; i <= 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      tick();
      if (count > peak) peak = count;
    end
    wr_en = 1'b0;
    for (int c = 0; c < 2000 && lq.size() < base + 16; c++) begin
      tick();
      if (count > peak) peak = count;
    end
    chk("burst_launches", lq.size() - base, 16);
    for (int i = 0; i < 16; i++) chk($sformatf("burst_byte%0d", i), lq_at(base + i), i + 1);
    chk("burst_peak_count", peak, 15);
    chk("burst_ovf", ovf, 0);
    repeat (FRAME + 5) tick();
    chk("burst_empty", empty, 1);

    // Overflow with transmitter held busy
    model_en = 1'b0;
    h_active = 1'b1;
    h_done   = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'hA0 + 8'(i);
      tick();
    end
    chk("ovf_full16", {full, count, ovf}, {1'b1, 5'd16, 1'b0});
    wr_data = 8'hB0;
    tick();
    wr_en = 1'b0;
    chk("ovf_dropped", {full, count, ovf}, {1'b1, 5'd16, 1'b1});
    base     = lq.size();
    model_en = 1'b1;
    wait_launches(base + 16, 1000, "ovf_launch_wait");
    repeat (60) tick();
    chk("ovf_launches", lq.size() - base, 16);
    for (int i = 0; i < 16; i++) chk($sformatf("ovf_byte%0d", i), lq_at(base + i), 32'hA0 + i);
    chk("ovf_sticky", ovf, 1);

    // Reset while 5 bytes queued and a frame in flight
    base = lq.size();
    for (int i = 0; i < 6; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'hD0 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    chk("mid_queued", {count, tx_active}, {5'd5, 1'b1});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_reset", {count, empty, tx_dv, ovf}, {5'd0, 1'b1, 1'b0, 1'b0});
    wr_en   = 1'b1;
    wr_data = 8'hC5;
    tick();
    wr_en = 1'b0;
    b2 = lq.size();
    for (int c = 0; c < 200 && tx_active; c++) tick();
    chk("mid_frame_end", tx_active, 0);
    chk("mid_no_launch_while_active", lq.size() - b2, 0);
    wait_launches(b2 + 1, 20, "mid_launch_wait");
    chk("mid_byte", lq_at(b2), 32'hC5);

    // Stalled transmitter: watchdog behaviour depends on build
    repeat (FRAME + 5) tick();
    model_en = 1'b0;
    h_active = 1'b0;
    h_done   = 1'b0;
    base     = lq.size();
    wr_en    = 1'b1;
    wr_data  = 8'hE1;
    tick();
    wr_data  = 8'hE2;
    tick();
    wr_en = 1'b0;
    repeat (150) tick();
    chk("stall_first_byte", lq_at(base), 32'hE1);
`ifdef UART_TX_FIFO_WDOG_EN
    chk("wdog_err", wdog_err, 1);
    chk("wdog_launches", lq.size() - base, 2);
    chk("wdog_next_byte", lq_at(base + 1), 32'hE2);
    chk("wdog_count", count, 0);
`else
    chk("wdog_err", wdog_err, 0);
    chk("stall_launches", lq.size() - base, 1);
    chk("stall_count", count, 1);
`endif

    chk("dv_single_cycle", dbl, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
